// File: rtl/ram_drain_ctrl.sv
// Drains words stored in a dual-port RAM by the upstream writer and streams them out
// over a valid/ready interface once the writer has been quiet for QUIET_CYCLES cycles.
module ram_drain_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH    = 9,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wren_i,
    input  logic [CNT_WIDTH-1:0]  word_count_i,
    output logic                  rden_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QuietMax = QW'(QUIET_CYCLES);

    typedef enum logic [1:0] {StIdle, StReq, StLat, StSend} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  sent_cnt_q, sent_cnt_d;
    logic [QW-1:0]         quiet_cnt_q, quiet_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  pending;
    logic                  pend_one;

    // Modular difference keeps pending correct when sent_cnt rolls over.
    assign pending  = word_count_i - sent_cnt_q;
    assign pend_one = (pending == CNT_WIDTH'(1));

    always_comb begin
        quiet_cnt_d = quiet_cnt_q;
        if (wren_i) begin
            quiet_cnt_d = '0;
        end else if (quiet_cnt_q != QuietMax) begin
            quiet_cnt_d = quiet_cnt_q + QW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        sent_cnt_d = sent_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = 1'b0;
        case (state_q)
            // Next-state quiet count lets REQ follow the QUIET_CYCLES-th idle cycle directly.
            StIdle: begin
                if ((pending != '0) && (quiet_cnt_d == QuietMax)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StLat;
            end
            StLat: begin
                data_d  = rd_data_i;
                valid_d = 1'b1;
                last_d  = pend_one;
                state_d = StSend;
            end
            StSend: begin
                if (ready_i) begin
                    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
                    sent_cnt_d = sent_cnt_q + CNT_WIDTH'(1);
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    if (last_q || pend_one) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            sent_cnt_q  <= '0;
            quiet_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            sent_cnt_q  <= sent_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign rden_o    = (state_q == StReq);
    assign rd_addr_o = rd_ptr_q;
    assign busy_o    = (state_q != StIdle);
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign last_o    = last_q;
    assign done_o    = done_q;

endmodule

// File: doc/ram_drain_ctrl.md
# ram_drain_ctrl

Drains the words that the FIFO-to-RAM write stage has stored in the dual-port RAM. Reads them through the RAM's second (read) port and presents them on a valid/ready output stream. Sits directly downstream of the write stage. It watches that stage's RAM write enable and running word count, and starts draining once the writer has gone quiet. Tracks its own sent count, so words stored after a drain are picked up by the next drain.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM address width; read pointer wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 32, RAM word / stream width
- CNT_WIDTH, 9, width of writer word count and internal sent count
- QUIET_CYCLES, 4, consecutive cycles with wren_i low required before a drain starts (≥1)

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- wren_i  in  1  write enable of upstream writer into RAM port A
- word_count_i  in  CNT_WIDTH  upstream running count of words written
- rden_o  out  1  RAM port B read enable
- rd_addr_o  out  ADDR_WIDTH  RAM port B address
- rd_data_i  in  DATA_WIDTH  RAM port B data, valid one cycle after rden_o
- data_o  out  DATA_WIDTH  stream data (registered)
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready from consumer
- last_o  out  1  qualifies final word of current drain
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse after last word accepted

## Operation
- pending = (word_count_i − sent_cnt) mod 2^CNT_WIDTH; pending ≠ 0 means unread words exist.
- quiet_cnt: cleared to 0 in any cycle wren_i=1; otherwise increments, saturating at QUIET_CYCLES.
- FSM states: IDLE, REQ, LAT, SEND.
  - IDLE: if pending≠0 and quiet_cnt==QUIET_CYCLES → REQ; else stay.
  - REQ: rden_o=1, rd_addr_o=rd_ptr; → LAT.
  - LAT: register rd_data_i into data_o; set valid_o=1; set last_o=(pending==1); → SEND.
  - SEND: hold data_o, valid_o, last_o stable while ready_i=0. On ready_i=1:
    - rd_ptr+1, sent_cnt+1, valid_o→0.
    - If pending==1, pulse done_o and → IDLE; else → REQ.
- pending is re-sampled live in SEND, so words written during a drain extend it.
  - last_o is fixed at LAT time. A word that arrives after LAT of the word flagged last_o is drained by the next drain.
  - Whenever last_o=1 the transfer ends the drain.
- wren_i has no effect on an ongoing drain; it only gates the start of a drain.
- rd_addr_o holds rd_ptr in all states; rden_o is high only in REQ.
- Wrap: rd_ptr rolls from 2^ADDR_WIDTH−1 to 0. sent_cnt rolls modulo 2^CNT_WIDTH, and pending arithmetic stays correct across the roll.

## Timing
- Reset (reset_i high at an edge): state=IDLE, rd_ptr=0, sent_cnt=0, quiet_cnt=0, rden_o=0, rd_addr_o=0, data_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0.
- Reset mid-drain: the word in flight is discarded, valid_o drops the next cycle, and no done_o is produced.
- Start latency: the writer's last wren_i=1 is in cycle t. quiet_cnt reaches QUIET_CYCLES at end of cycle t+QUIET_CYCLES. REQ occupies cycle t+QUIET_CYCLES+1.
- Per word: REQ (1) + LAT (1) + SEND (≥1). First valid_o is 2 cycles after entering REQ. Peak throughput is 1 word per 3 cycles with ready_i held high.
- done_o is high for the single cycle after the accepting edge of the last word, coinciding with return to IDLE.
- Stream rule: data_o and last_o must not change while valid_o=1 and ready_i=0.

## Test plan
- Reset then idle: word_count_i=0, wren_i toggling → valid_o, rden_o, busy_o stay 0 for 100 cycles.
- Basic drain: preload RAM[0..4]=0xA0..0xA4, word_count_i=5, wren_i low, ready_i=1 → rden_o first at cycle QUIET_CYCLES+1. Stream is 0xA0..0xA4 with last_o only on 0xA4. done_o pulses once. Then rd_ptr=5.
- Backpressure: same setup, ready_i low for 7 cycles on the 2nd word → data_o stays 0xA1 with valid_o high throughout, no words lost or duplicated.
- Quiet gating: wren_i pulses every 3 cycles with QUIET_CYCLES=4 → no drain. Once pulses stop → drain begins exactly 5 cycles after the last pulse.
- Incremental drain and wrap: preset sent_cnt and rd_ptr near top by draining 510 words, then word_count_i advances to 515 (mod 512 = 3) → 5 words drained. rd_addr_o goes 510, 511, 512, 513, 514 (mod 1024), and pending returns to 0.
- Reset mid-drain: assert reset_i while in SEND → next cycle valid_o=0, busy_o=0, no done_o. Re-drain then restarts from address 0.
